// File: rtl/cpu32_pkg.sv
// Shared CPU32 definitions: register-file geometry and the writeback request type
// passed between the writeback arbiter and its ALU result buffer.
package cpu32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register mask; x0 is never tracked, so it maps to an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (rd != '0) m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding ALU writeback requests; full/empty come from a
// registered occupancy count so they never depend on same-cycle push/pop.
module wb_fifo
    import cpu32_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define
    // validity, so stale contents are unreachable after reset.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Writeback arbiter and load scoreboard: merges load returns and buffered ALU
// results into one registered regfile write per cycle and tracks pending loads.
module regfile_wb
    import cpu32_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ALU_VALID,
    output logic                  ALU_READY,
    input  logic [REG_ADDR_W-1:0] ALU_WADDR,
    input  logic [XLEN-1:0]       ALU_WDATA,
    input  logic                  LD_ISSUE,
    input  logic [REG_ADDR_W-1:0] LD_ISSUE_RD,
    input  logic                  LD_VALID,
    input  logic [REG_ADDR_W-1:0] LD_RD,
    input  logic [XLEN-1:0]       LD_WDATA,
    output logic                  WE,
    output logic [REG_ADDR_W-1:0] WADDR,
    output logic [XLEN-1:0]       WDATA,
    output logic [NUM_REGS-1:0]   BUSY,
    output logic                  ERR
);

    wb_req_t fifo_head;
    wb_req_t alu_req;
    wb_req_t sel_req;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;
    logic    alu_acc;
    logic    sel_valid;
    logic    orphan;
    logic    overflow;

    assign alu_req   = '{addr: ALU_WADDR, data: ALU_WDATA};
    assign ALU_READY = !fifo_full;
    assign alu_acc   = ALU_VALID && ALU_READY;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wb_req_t)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (fifo_push),
        .push_data (alu_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Loads cannot stall, so they always win; buffered ALU results drain before
    // any new ALU result may bypass, which keeps ALU order strict.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (LD_VALID) begin
            sel_valid = 1'b1;
            sel_req   = '{addr: LD_RD, data: LD_WDATA};
            fifo_push = alu_acc;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_req   = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = alu_acc;
        end else if (ALU_VALID) begin
            sel_valid = 1'b1;
            sel_req   = alu_req;
        end
    end

    assign orphan   = LD_VALID && (LD_RD != '0) && !BUSY[LD_RD];
    assign overflow = fifo_push && fifo_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE    <= 1'b0;
            WADDR <= '0;
            WDATA <= '0;
            BUSY  <= '0;
            ERR   <= 1'b0;
        end else begin
            // x0 writes are consumed and still update address/data, but never strobe.
            WE <= sel_valid && (sel_req.addr != '0);
            if (sel_valid) begin
                WADDR <= sel_req.addr;
                WDATA <= sel_req.data;
            end
            // Set is applied after clear so a same-cycle issue of the returning rd wins.
            BUSY <= (BUSY & ~(LD_VALID ? reg_mask(LD_RD) : '0))
                  | (LD_ISSUE ? reg_mask(LD_ISSUE_RD) : '0);
            ERR  <= ERR || orphan || overflow;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb: reset, bypass, load/ALU collision
// ordering, scoreboard, x0/orphan handling and reset in the middle of a burst.
module tb_regfile_wb;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ALU_VALID;
    logic        ALU_READY;
    logic [4:0]  ALU_WADDR;
    logic [31:0] ALU_WDATA;
    logic        LD_ISSUE;
    logic [4:0]  LD_ISSUE_RD;
    logic        LD_VALID;
    logic [4:0]  LD_RD;
    logic [31:0] LD_WDATA;
    logic        WE;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic [31:0] BUSY;
    logic        ERR;

    int tests = 0;
    int fails = 0;

    regfile_wb #(.FIFO_DEPTH(2)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ALU_VALID   (ALU_VALID),
        .ALU_READY   (ALU_READY),
        .ALU_WADDR   (ALU_WADDR),
        .ALU_WDATA   (ALU_WDATA),
        .LD_ISSUE    (LD_ISSUE),
        .LD_ISSUE_RD (LD_ISSUE_RD),
        .LD_VALID    (LD_VALID),
        .LD_RD       (LD_RD),
        .LD_WDATA    (LD_WDATA),
        .WE          (WE),
        .WADDR       (WADDR),
        .WDATA       (WDATA),
        .BUSY        (BUSY),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        ALU_VALID   = 1'b0;
        ALU_WADDR   = '0;
        ALU_WDATA   = '0;
        LD_ISSUE    = 1'b0;
        LD_ISSUE_RD = '0;
        LD_VALID    = 1'b0;
        LD_RD       = '0;
        LD_WDATA    = '0;
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (WE !== 1'b0)        begin fails++; $display("FAIL reset_we: got %b want 0", WE); end
        tests++; if (WADDR !== 5'd0)     begin fails++; $display("FAIL reset_waddr: got %0d want 0", WADDR); end
        tests++; if (WDATA !== 32'd0)    begin fails++; $display("FAIL reset_wdata: got %h want 0", WDATA); end
        tests++; if (BUSY !== 32'd0)     begin fails++; $display("FAIL reset_busy: got %h want 0", BUSY); end
        tests++; if (ALU_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ALU_READY); end
        tests++; if (ERR !== 1'b0)       begin fails++; $display("FAIL reset_err: got %b want 0", ERR); end
    endtask

    task automatic test_alu_bypass();
        do_reset();
        ALU_VALID = 1'b1; ALU_WADDR = 5'd3; ALU_WDATA = 32'hDEADBEEF;
        tests++; if (ALU_READY !== 1'b1) begin fails++; $display("FAIL bypass_ready: got %b want 1", ALU_READY); end
        tick();
        idle_inputs();
        tests++; if (WE !== 1'b1)           begin fails++; $display("FAIL bypass_we: got %b want 1", WE); end
        tests++; if (WADDR !== 5'd3)        begin fails++; $display("FAIL bypass_waddr: got %0d want 3", WADDR); end
        tests++; if (WDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_wdata: got %h want deadbeef", WDATA); end
        tick();
        tests++; if (WE !== 1'b0)           begin fails++; $display("FAIL bypass_we_pulse: got %b want 0", WE); end
    endtask

    task automatic test_collision();
        logic        exp_rdy  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  exp_addr [7] = '{5'd10, 5'd10, 5'd10, 5'd4, 5'd5, 5'd6, 5'd0};
        logic [31:0] exp_data [7] = '{32'hCAFEBABE, 32'hCAFEBABE, 32'hCAFEBABE,
                                      32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0};
        int  idx = 0;
        logic acc;
        do_reset();
        // Mark rd 10 pending so only the 2nd and 3rd returns are orphans.
        LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd10;
        tick();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            LD_VALID  = (c < 3);
            LD_RD     = 5'd10;
            LD_WDATA  = 32'hCAFEBABE;
            ALU_VALID = (idx < 3);
            ALU_WADDR = 5'(4 + idx);
            ALU_WDATA = 32'hA0 + 32'(idx);
            tests++; if (ALU_READY !== exp_rdy[c])
                begin fails++; $display("FAIL coll_ready[%0d]: got %b want %b", c, ALU_READY, exp_rdy[c]); end
            acc = ALU_VALID && ALU_READY;
            tick();
            if (acc) idx++;
            tests++; if (WE !== exp_we[c])
                begin fails++; $display("FAIL coll_we[%0d]: got %b want %b", c, WE, exp_we[c]); end
            if (exp_we[c]) begin
                tests++; if (WADDR !== exp_addr[c])
                    begin fails++; $display("FAIL coll_waddr[%0d]: got %0d want %0d", c, WADDR, exp_addr[c]); end
                tests++; if (WDATA !== exp_data[c])
                    begin fails++; $display("FAIL coll_wdata[%0d]: got %h want %h", c, WDATA, exp_data[c]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        do_reset();
        LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd7;
        tests++; if (BUSY !== 32'h0) begin fails++; $display("FAIL sb_before_issue: got %h want 0", BUSY); end
        tick();
        idle_inputs();
        for (int c = 1; c < 5; c++) begin
            tests++; if (BUSY !== 32'h80) begin fails++; $display("FAIL sb_pending[%0d]: got %h want 80", c, BUSY); end
            tick();
        end
        tests++; if (BUSY !== 32'h80) begin fails++; $display("FAIL sb_at_return: got %h want 80", BUSY); end
        LD_VALID = 1'b1; LD_RD = 5'd7; LD_WDATA = 32'h77;
        tick();
        idle_inputs();
        tests++; if (BUSY !== 32'h0)  begin fails++; $display("FAIL sb_cleared: got %h want 0", BUSY); end
        tests++; if (WE !== 1'b1 || WADDR !== 5'd7) begin fails++; $display("FAIL sb_ld_write: got we=%b addr=%0d want we=1 addr=7", WE, WADDR); end
        tests++; if (ERR !== 1'b0)    begin fails++; $display("FAIL sb_err: got %b want 0", ERR); end
        LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd7;
        tick();
        LD_VALID = 1'b1; LD_RD = 5'd7; LD_WDATA = 32'h78;
        tick();
        idle_inputs();
        tests++; if (BUSY !== 32'h80) begin fails++; $display("FAIL sb_set_wins: got %h want 80", BUSY); end
        tests++; if (ERR !== 1'b0)    begin fails++; $display("FAIL sb_set_wins_err: got %b want 0", ERR); end
        LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd0;
        tick();
        idle_inputs();
        tests++; if (BUSY !== 32'h80) begin fails++; $display("FAIL sb_x0_issue: got %h want 80", BUSY); end
    endtask

    task automatic test_x0_orphan();
        do_reset();
        ALU_VALID = 1'b1; ALU_WADDR = 5'd0; ALU_WDATA = 32'h12345678;
        tick();
        idle_inputs();
        tests++; if (WE !== 1'b0)            begin fails++; $display("FAIL x0_we: got %b want 0", WE); end
        tests++; if (WDATA !== 32'h12345678) begin fails++; $display("FAIL x0_wdata: got %h want 12345678", WDATA); end
        tests++; if (ALU_READY !== 1'b1)     begin fails++; $display("FAIL x0_ready: got %b want 1", ALU_READY); end
        ALU_VALID = 1'b1; ALU_WADDR = 5'd1; ALU_WDATA = 32'h11;
        tick();
        idle_inputs();
        tests++; if (WE !== 1'b1 || WADDR !== 5'd1 || WDATA !== 32'h11)
            begin fails++; $display("FAIL x0_next: got we=%b addr=%0d data=%h want 1/1/11", WE, WADDR, WDATA); end
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL orphan_pre: got %b want 0", ERR); end
        LD_VALID = 1'b1; LD_RD = 5'd9; LD_WDATA = 32'h99;
        tick();
        idle_inputs();
        tests++; if (WE !== 1'b1 || WADDR !== 5'd9 || WDATA !== 32'h99)
            begin fails++; $display("FAIL orphan_write: got we=%b addr=%0d data=%h want 1/9/99", WE, WADDR, WDATA); end
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL orphan_err: got %b want 1", ERR); end
        repeat (3) tick();
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL orphan_sticky: got %b want 1", ERR); end
        do_reset();
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL orphan_reset: got %b want 0", ERR); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd12;
        LD_VALID = 1'b1; LD_RD = 5'd10; LD_WDATA = 32'h1;
        ALU_VALID = 1'b1; ALU_WADDR = 5'd20; ALU_WDATA = 32'h20;
        tick();
        LD_ISSUE = 1'b0;
        ALU_WADDR = 5'd21; ALU_WDATA = 32'h21;
        tick();
        idle_inputs();
        tests++; if (ALU_READY !== 1'b0) begin fails++; $display("FAIL mid_full: got %b want 0", ALU_READY); end
        tests++; if (BUSY[12] !== 1'b1)  begin fails++; $display("FAIL mid_busy_set: got %b want 1", BUSY[12]); end
        tests++; if (WE !== 1'b1)        begin fails++; $display("FAIL mid_we_before: got %b want 1", WE); end
        #2;
        RST_N = 1'b0;
        #1;
        tests++; if (WE !== 1'b0)        begin fails++; $display("FAIL mid_rst_we: got %b want 0", WE); end
        tests++; if (BUSY !== 32'h0)     begin fails++; $display("FAIL mid_rst_busy: got %h want 0", BUSY); end
        tests++; if (ERR !== 1'b0)       begin fails++; $display("FAIL mid_rst_err: got %b want 0", ERR); end
        tests++; if (ALU_READY !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", ALU_READY); end
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++; if (WE !== 1'b0) begin fails++; $display("FAIL mid_no_stale[%0d]: got %b want 0", c, WE); end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        test_reset();
        test_alu_bypass();
        test_collision();
        test_scoreboard();
        test_x0_orphan();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback arbiter and load scoreboard sitting directly upstream of `regfile`, and the only driver of its write port (WE/WADDR/WDATA). Merges two result streams: ALU results via valid/ready, and load returns that cannot be back-pressured. Emits at most one registered regfile write per cycle. Keeps a per-register pending-load bitmap that decode uses for RAW/WAW stalls.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: ALU result buffer entries; power of two, ≥2.

Ports:
- `CLK`  in  1: clock; all state changes on rising edge.
- `RST_N`  in  1: asynchronous active-low reset.
- `ALU_VALID`  in  1: ALU result present.
- `ALU_READY`  out  1: ALU result accepted this cycle when high with ALU_VALID.
- `ALU_WADDR`  in  5: destination register.
- `ALU_WDATA`  in  32: result data.
- `LD_ISSUE`  in  1: load issued this cycle; marks destination pending.
- `LD_ISSUE_RD`  in  5: destination of the issued load.
- `LD_VALID`  in  1: load data returning; always accepted, no ready.
- `LD_RD`  in  5: destination of the returning load.
- `LD_WDATA`  in  32: returned data.
- `WE`  out  1: regfile write enable, registered.
- `WADDR`  out  5: regfile write address, registered.
- `WDATA`  out  32: regfile write data, registered.
- `BUSY`  out  32: pending-load bitmap, registered; bit 0 always 0.
- `ERR`  out  1: sticky error flag (orphan load return or FIFO overflow attempt).

## Operation
- Per-cycle select, in priority order:
  1. `LD_VALID`: write load data.
  2. FIFO non-empty: pop head and write it.
  3. `ALU_VALID` with FIFO empty: bypass ALU input straight to the output register.
  4. Otherwise `WE`=0 next cycle.
- ALU input not bypassed and accepted (`ALU_VALID && ALU_READY`) is pushed into the FIFO.
- `ALU_READY` = FIFO not full. It depends on registered count only, never on same-cycle pop.
- FIFO order is strict: no ALU entry overtakes an older one.
- Address 0: a selected write to register 0 is consumed (popped/accepted) but drives `WE`=0. `WADDR`/`WDATA` still update.
- Scoreboard:
  - `LD_ISSUE` sets `BUSY[LD_ISSUE_RD]`, except rd=0.
  - `LD_VALID` clears `BUSY[LD_RD]`.
  - Same rd issued and returned in one cycle: set wins, bit stays 1.
- `LD_VALID` with `BUSY[LD_RD]`=0 and rd≠0: data is still written, and `ERR` sets.
- ALU writes to a register with its BUSY bit set are not blocked here. Decode guarantees ordering by stalling on `BUSY`.

## Timing
- Reset (async assert, sync-to-CLK deassert handled upstream):
  - `WE`=0, `WADDR`=0, `WDATA`=0, `BUSY`=0, `ERR`=0.
  - FIFO empty, so `ALU_READY`=1.
- Latency, input to `WE` high:
  - Load: 1 cycle.
  - ALU when idle: 1 cycle (bypass).
  - ALU behind k queued entries and no loads: k+1 cycles.
- Continuous `LD_VALID` starves the FIFO. No fairness is guaranteed; the memory interface bounds load bursts.
- FIFO full: `ALU_READY`=0 that cycle. A pop that same cycle does not raise `ALU_READY` until the next cycle.
- `BUSY` updates 1 cycle after `LD_ISSUE`/`LD_VALID`. Decode sees a set bit from the cycle after issue.
- Reset mid-operation: queued ALU results and pending BUSY bits are discarded, and no write is emitted.
- `WE` is a single-cycle pulse per write. Back-to-back writes on consecutive cycles are allowed.

## Structure
- Shared package `cpu32_pkg`: `REG_ADDR_W`=5, `XLEN`=32, `NUM_REGS`=32, and a typedef `wb_req_t` {addr, data}.
- One sub-module: `wb_fifo`, a synchronous FIFO with count-based full/empty and async active-low reset, parameterised on depth and `wb_req_t`.
- Select logic, output register and scoreboard stay in `regfile_wb`.

## Test plan
- Reset then idle:
  - Stimulus: `RST_N` low, then high.
  - Required: `WE`=0, `BUSY`=0, `ALU_READY`=1, `ERR`=0.
- ALU bypass:
  - Stimulus: `ALU_VALID`, rd=3, data=DEADBEEF for one cycle.
  - Required: next cycle `WE`=1, `WADDR`=3, `WDATA`=DEADBEEF. Cycle after that `WE`=0.
- Collision and ordering:
  - Stimulus: `LD_VALID` rd=10 CAFEBABE for 3 cycles, with ALU rd=4/5/6 offered at the same time.
  - Required: three load writes, then 4, 5, 6 written in order.
  - Required: `ALU_READY` drops after 2 ALU results are accepted.
- Scoreboard:
  - Stimulus: `LD_ISSUE` rd=7, then `LD_VALID` rd=7 five cycles later.
  - Required: `BUSY[7]`=1 from cycle+1 until the cycle after return.
  - Required: with issue and return of rd=7 in the same cycle, `BUSY[7]` stays 1.
- x0 and orphan:
  - Stimulus: ALU write to rd=0.
  - Required: `WE`=0 and the entry is consumed.
  - Stimulus: `LD_VALID` rd=9 with `BUSY[9]`=0.
  - Required: write 9 occurs and `ERR`=1, sticky until reset.
- Reset mid-burst:
  - Stimulus: assert `RST_N` low with 2 entries queued.
  - Required: immediate `WE`=0, `BUSY`=0, and no queued write emitted after release.
